// File: rtl/stage_write_back_mlane_pkg.sv
// Shared definitions for the multi-lane write-back stage.
//   - Default lane count and data/address widths.
//   - Occupancy encoding of the two-entry buffer.
//   - Packed bundle layout. Mem-part-2 reuses it to build its output bundle.
//     Each lane record is packed LSB first as:
//       valid | pc | gpr_we | gpr_addr | gpr_data | cp0_we | cp0_addr | cp0_data
//     After the LANES lane records comes one merged HI/LO tail:
//       hi_we | lo_we | hi_data | lo_data
package stage_write_back_mlane_pkg;

    localparam int WB_LANES  = 2;
    localparam int WB_DATA_W = 32;
    localparam int WB_PC_W   = 32;
    localparam int WB_REG_AW = 5;
    localparam int WB_CNT_W  = 32;

    // Buffer occupancy. BUF_FULL means both head and skid hold a bundle.
    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state_e;

    localparam int WB_OFF_VALID = 0;
    localparam int WB_OFF_PC    = 1;

    function automatic int wb_off_gwe(input int pc_w);
        return WB_OFF_PC + pc_w;
    endfunction

    function automatic int wb_off_gaddr(input int pc_w);
        return wb_off_gwe(pc_w) + 1;
    endfunction

    function automatic int wb_off_gdata(input int pc_w, input int reg_aw);
        return wb_off_gaddr(pc_w) + reg_aw;
    endfunction

    function automatic int wb_off_cwe(input int pc_w, input int reg_aw, input int data_w);
        return wb_off_gdata(pc_w, reg_aw) + data_w;
    endfunction

    function automatic int wb_off_caddr(input int pc_w, input int reg_aw, input int data_w);
        return wb_off_cwe(pc_w, reg_aw, data_w) + 1;
    endfunction

    function automatic int wb_off_cdata(input int pc_w, input int reg_aw, input int data_w);
        return wb_off_caddr(pc_w, reg_aw, data_w) + reg_aw;
    endfunction

    function automatic int wb_lane_w(input int pc_w, input int reg_aw, input int data_w);
        return wb_off_cdata(pc_w, reg_aw, data_w) + data_w;
    endfunction

    function automatic int wb_bundle_w(input int lanes, input int pc_w, input int reg_aw,
                                       input int data_w);
        return lanes * wb_lane_w(pc_w, reg_aw, data_w) + 2 + 2 * data_w;
    endfunction

endpackage

// File: rtl/stage_write_back_mlane_wb_skid_buf.sv
// wb_skid_buf: generic two-entry FIFO (head + skid) with a registered ready.
// Ports:
//   clk, reset   clock; synchronous active-high reset
//   flush        empties both entries next cycle (wins over a same-cycle accept)
//   in_valid     producer offers in_data
//   in_data      WIDTH-bit payload
//   in_ready     registered; high when the skid entry is free
//   pop          consumer takes the head this cycle
//   state        occupancy (empty / one / full)
//   head_data    payload of the head entry
// Handshake: a transfer happens on a rising edge where in_valid and in_ready
// are both high. The producer must keep in_valid and in_data stable until that
// edge. in_ready depends only on registered state, so it has no combinational
// path from in_valid or pop.
module wb_skid_buf
    import stage_write_back_mlane_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    input  logic             pop,
    output buf_state_e       state,
    output logic [WIDTH-1:0] head_data
);

    buf_state_e       state_q, state_d;
    logic             in_ready_q, in_ready_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] skid_q, skid_d;

    logic head_valid, skid_valid;
    logic head_valid_n, skid_valid_n;
    logic accept;

    always_comb begin
        head_valid   = (state_q != BUF_EMPTY);
        skid_valid   = (state_q == BUF_FULL);
        accept       = in_valid & in_ready_q;

        head_valid_n = head_valid;
        skid_valid_n = skid_valid;
        head_d       = head_q;
        skid_d       = skid_q;

        // Pop first, so the skid entry moves up before the new bundle lands.
        if (pop && head_valid) begin
            head_valid_n = skid_valid;
            head_d       = skid_q;
            skid_valid_n = 1'b0;
        end

        // An accept always finds a free slot, because ready was low whenever
        // the skid entry was occupied. The !skid_valid_n guard keeps a held
        // bundle from ever being overwritten.
        if (accept && !flush) begin
            if (!head_valid_n) begin
                head_valid_n = 1'b1;
                head_d       = in_data;
            end else if (!skid_valid_n) begin
                skid_valid_n = 1'b1;
                skid_d       = in_data;
            end
        end

        if (flush) begin
            head_valid_n = 1'b0;
            skid_valid_n = 1'b0;
        end

        if (skid_valid_n) begin
            state_d = BUF_FULL;
        end else if (head_valid_n) begin
            state_d = BUF_ONE;
        end else begin
            state_d = BUF_EMPTY;
        end

        in_ready_d = ~skid_valid_n;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= BUF_EMPTY;
            in_ready_q <= 1'b1;
            head_q     <= '0;
            skid_q     <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            head_q     <= head_d;
            skid_q     <= skid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign state     = state_q;
    assign head_data = head_q;

endmodule

// File: rtl/stage_write_back_mlane.sv
// stage_write_back_mlane: multi-lane write-back (retire) stage.
// Bundles from mem-part-2 are resolved for write collisions as they are
// captured. They then queue in a two-entry buffer, and the head commits
// whenever wb_hold is low.
// Ports:
//   clk, reset, flush                clock; sync active-high reset; buffer flush
//   in_valid / in_ready              bundle handshake from mem-part-2 (ready registered)
//   in_lane_valid, in_pc             per-lane presence and PC
//   in_gpr_we/addr/data              per-lane GPR write
//   in_hi_we, in_lo_we, in_hi, in_lo per-lane HI/LO write
//   in_cp0_we/addr/data              per-lane CP0 write
//   wb_hold                          blocks the commit of the head this cycle
//   wb_lane_valid                    lanes that commit this cycle
//   w_en/w_addr/w_data               GPR write ports
//   w_en_hi/w_en_lo/data_hi/data_lo  merged HI/LO write
//   cp0_w_en/cp0_w_addr/cp0_w_data   CP0 write ports
//   pc_wb                            head-bundle PCs, zero when the buffer is empty
//   retire_cnt                       committed instructions since reset (wraps)
module stage_write_back_mlane
    import stage_write_back_mlane_pkg::*;
#(
    parameter int LANES  = WB_LANES,
    parameter int DATA_W = WB_DATA_W,
    parameter int PC_W   = WB_PC_W,
    parameter int REG_AW = WB_REG_AW,
    parameter int CNT_W  = WB_CNT_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES-1:0]         in_lane_valid,
    input  logic [LANES*PC_W-1:0]    in_pc,
    input  logic [LANES-1:0]         in_gpr_we,
    input  logic [LANES*REG_AW-1:0]  in_gpr_addr,
    input  logic [LANES*DATA_W-1:0]  in_gpr_data,
    input  logic [LANES-1:0]         in_hi_we,
    input  logic [LANES-1:0]         in_lo_we,
    input  logic [LANES*DATA_W-1:0]  in_hi,
    input  logic [LANES*DATA_W-1:0]  in_lo,
    input  logic [LANES-1:0]         in_cp0_we,
    input  logic [LANES*REG_AW-1:0]  in_cp0_addr,
    input  logic [LANES*DATA_W-1:0]  in_cp0_data,
    input  logic                     wb_hold,
    output logic [LANES-1:0]         wb_lane_valid,
    output logic [LANES-1:0]         w_en,
    output logic [LANES*REG_AW-1:0]  w_addr,
    output logic [LANES*DATA_W-1:0]  w_data,
    output logic                     w_en_hi,
    output logic                     w_en_lo,
    output logic [DATA_W-1:0]        data_hi,
    output logic [DATA_W-1:0]        data_lo,
    output logic [LANES-1:0]         cp0_w_en,
    output logic [LANES*REG_AW-1:0]  cp0_w_addr,
    output logic [LANES*DATA_W-1:0]  cp0_w_data,
    output logic [LANES*PC_W-1:0]    pc_wb,
    output logic [CNT_W-1:0]         retire_cnt
);

    localparam int OFF_GWE   = wb_off_gwe(PC_W);
    localparam int OFF_GADDR = wb_off_gaddr(PC_W);
    localparam int OFF_GDATA = wb_off_gdata(PC_W, REG_AW);
    localparam int OFF_CWE   = wb_off_cwe(PC_W, REG_AW, DATA_W);
    localparam int OFF_CADDR = wb_off_caddr(PC_W, REG_AW, DATA_W);
    localparam int OFF_CDATA = wb_off_cdata(PC_W, REG_AW, DATA_W);
    localparam int LANE_W    = wb_lane_w(PC_W, REG_AW, DATA_W);
    localparam int HL_BASE   = LANES * LANE_W;
    localparam int BUNDLE_W  = wb_bundle_w(LANES, PC_W, REG_AW, DATA_W);

    logic [LANES-1:0]    gpr_keep;
    logic [LANES-1:0]    cp0_keep;
    logic [BUNDLE_W-1:0] cap_bundle;
    logic [BUNDLE_W-1:0] head_data;
    buf_state_e          buf_state;
    logic                head_valid;
    logic                commit;
    logic [CNT_W-1:0]    retire_inc;
    logic [CNT_W-1:0]    retire_cnt_q, retire_cnt_d;

    // Collision resolution. Lane index is program order, so a later lane that
    // writes the same register supersedes an earlier one. A write to GPR 0
    // is dropped because that register is hardwired to zero.
    always_comb begin
        gpr_keep = '0;
        cp0_keep = '0;
        for (int i = 0; i < LANES; i++) begin
            gpr_keep[i] = in_lane_valid[i] & in_gpr_we[i] &
                          (in_gpr_addr[i*REG_AW +: REG_AW] != '0);
            cp0_keep[i] = in_lane_valid[i] & in_cp0_we[i];
            for (int j = i + 1; j < LANES; j++) begin
                if (in_lane_valid[j] && in_gpr_we[j] &&
                    (in_gpr_addr[j*REG_AW +: REG_AW] == in_gpr_addr[i*REG_AW +: REG_AW])) begin
                    gpr_keep[i] = 1'b0;
                end
                if (in_lane_valid[j] && in_cp0_we[j] &&
                    (in_cp0_addr[j*REG_AW +: REG_AW] == in_cp0_addr[i*REG_AW +: REG_AW])) begin
                    cp0_keep[i] = 1'b0;
                end
            end
        end
    end

    // Pack the resolved bundle. HI and LO collapse to one write each. The
    // loop runs in lane order, so the highest writing lane is the one kept.
    always_comb begin
        cap_bundle = '0;
        for (int i = 0; i < LANES; i++) begin
            cap_bundle[i*LANE_W + WB_OFF_VALID]         = in_lane_valid[i];
            cap_bundle[i*LANE_W + WB_OFF_PC +: PC_W]    = in_pc[i*PC_W +: PC_W];
            cap_bundle[i*LANE_W + OFF_GWE]              = gpr_keep[i];
            cap_bundle[i*LANE_W + OFF_GADDR +: REG_AW]  = in_gpr_addr[i*REG_AW +: REG_AW];
            cap_bundle[i*LANE_W + OFF_GDATA +: DATA_W]  = in_gpr_data[i*DATA_W +: DATA_W];
            cap_bundle[i*LANE_W + OFF_CWE]              = cp0_keep[i];
            cap_bundle[i*LANE_W + OFF_CADDR +: REG_AW]  = in_cp0_addr[i*REG_AW +: REG_AW];
            cap_bundle[i*LANE_W + OFF_CDATA +: DATA_W]  = in_cp0_data[i*DATA_W +: DATA_W];
            if (in_lane_valid[i] && in_hi_we[i]) begin
                cap_bundle[HL_BASE]                     = 1'b1;
                cap_bundle[HL_BASE + 2 +: DATA_W]       = in_hi[i*DATA_W +: DATA_W];
            end
            if (in_lane_valid[i] && in_lo_we[i]) begin
                cap_bundle[HL_BASE + 1]                 = 1'b1;
                cap_bundle[HL_BASE + 2 + DATA_W +: DATA_W] = in_lo[i*DATA_W +: DATA_W];
            end
        end
    end

    wb_skid_buf #(
        .WIDTH(BUNDLE_W)
    ) u_skid (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .in_valid (in_valid),
        .in_data  (cap_bundle),
        .in_ready (in_ready),
        .pop      (commit),
        .state    (buf_state),
        .head_data(head_data)
    );

    assign head_valid = (buf_state != BUF_EMPTY);
    assign commit     = head_valid & ~wb_hold;

    // Commit outputs come straight from the head entry and are forced to
    // zero unless it actually commits. pc_wb only needs a valid head.
    always_comb begin
        wb_lane_valid = '0;
        w_en          = '0;
        w_addr        = '0;
        w_data        = '0;
        cp0_w_en      = '0;
        cp0_w_addr    = '0;
        cp0_w_data    = '0;
        w_en_hi       = 1'b0;
        w_en_lo       = 1'b0;
        data_hi       = '0;
        data_lo       = '0;
        pc_wb         = '0;
        retire_inc    = '0;
        for (int i = 0; i < LANES; i++) begin
            if (head_valid) begin
                pc_wb[i*PC_W +: PC_W] = head_data[i*LANE_W + WB_OFF_PC +: PC_W];
            end
            if (commit) begin
                wb_lane_valid[i]               = head_data[i*LANE_W + WB_OFF_VALID];
                w_en[i]                        = head_data[i*LANE_W + OFF_GWE];
                w_addr[i*REG_AW +: REG_AW]     = head_data[i*LANE_W + OFF_GADDR +: REG_AW];
                w_data[i*DATA_W +: DATA_W]     = head_data[i*LANE_W + OFF_GDATA +: DATA_W];
                cp0_w_en[i]                    = head_data[i*LANE_W + OFF_CWE];
                cp0_w_addr[i*REG_AW +: REG_AW] = head_data[i*LANE_W + OFF_CADDR +: REG_AW];
                cp0_w_data[i*DATA_W +: DATA_W] = head_data[i*LANE_W + OFF_CDATA +: DATA_W];
                retire_inc = retire_inc + CNT_W'(head_data[i*LANE_W + WB_OFF_VALID]);
            end
        end
        if (commit) begin
            w_en_hi = head_data[HL_BASE];
            w_en_lo = head_data[HL_BASE + 1];
            data_hi = head_data[HL_BASE + 2 +: DATA_W];
            data_lo = head_data[HL_BASE + 2 + DATA_W +: DATA_W];
        end
        // The counter wraps silently modulo 2^CNT_W.
        retire_cnt_d = retire_cnt_q + retire_inc;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            retire_cnt_q <= '0;
        end else begin
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_stage_write_back_mlane.sv
module tb_stage_write_back_mlane;

    localparam int L  = 2;
    localparam int DW = 32;
    localparam int PW = 32;
    localparam int AW = 5;
    localparam int CW = 4;

    logic clk, reset, flush, in_valid, wb_hold, in_ready;
    logic [L-1:0]          s_lv, s_gwe, s_hwe, s_lwe, s_cwe;
    logic [L-1:0][PW-1:0]  s_pc;
    logic [L-1:0][AW-1:0]  s_gaddr, s_caddr;
    logic [L-1:0][DW-1:0]  s_gdata, s_hi, s_lo, s_cdata;

    logic [L-1:0]          wb_lane_valid, w_en, cp0_w_en;
    logic [L-1:0][AW-1:0]  w_addr, cp0_w_addr;
    logic [L-1:0][DW-1:0]  w_data, cp0_w_data;
    logic                  w_en_hi, w_en_lo;
    logic [DW-1:0]         data_hi, data_lo;
    logic [L-1:0][PW-1:0]  pc_wb;
    logic [CW-1:0]         retire_cnt;

    typedef struct packed {
        logic [L-1:0]          lv;
        logic [L-1:0]          gen;
        logic [L-1:0][AW-1:0]  gaddr;
        logic [L-1:0][DW-1:0]  gdata;
        logic [L-1:0]          cen;
        logic [L-1:0][AW-1:0]  caddr;
        logic [L-1:0][DW-1:0]  cdata;
        logic                  hen;
        logic                  len;
        logic [DW-1:0]         hdata;
        logic [DW-1:0]         ldata;
        logic [L-1:0][PW-1:0]  pc;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          mon_e;
    int            n_tests = 0;
    int            n_fail  = 0;
    logic [CW-1:0] model_cnt = '0;
    logic [CW-1:0] cnt_snap;
    logic [31:0]   pc_base = 32'h1000;

    stage_write_back_mlane #(
        .LANES(L), .DATA_W(DW), .PC_W(PW), .REG_AW(AW), .CNT_W(CW)
    ) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_lane_valid(s_lv), .in_pc(s_pc),
        .in_gpr_we(s_gwe), .in_gpr_addr(s_gaddr), .in_gpr_data(s_gdata),
        .in_hi_we(s_hwe), .in_lo_we(s_lwe), .in_hi(s_hi), .in_lo(s_lo),
        .in_cp0_we(s_cwe), .in_cp0_addr(s_caddr), .in_cp0_data(s_cdata),
        .wb_hold(wb_hold), .wb_lane_valid(wb_lane_valid),
        .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
        .w_en_hi(w_en_hi), .w_en_lo(w_en_lo), .data_hi(data_hi), .data_lo(data_lo),
        .cp0_w_en(cp0_w_en), .cp0_w_addr(cp0_w_addr), .cp0_w_data(cp0_w_data),
        .pc_wb(pc_wb), .retire_cnt(retire_cnt)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: walk lanes from youngest to oldest; the first writer
    // seen for a register (or HI/LO) is the one that survives.
    function automatic exp_t model();
        exp_t        e;
        logic [31:0] g_taken, c_taken;
        e = '0;
        g_taken = '0;
        c_taken = '0;
        e.lv = s_lv;
        e.pc = s_pc;
        for (int i = L - 1; i >= 0; i--) begin
            if (s_lv[i] && s_gwe[i]) begin
                if (s_gaddr[i] != '0 && !g_taken[s_gaddr[i]]) begin
                    e.gen[i]   = 1'b1;
                    e.gaddr[i] = s_gaddr[i];
                    e.gdata[i] = s_gdata[i];
                end
                g_taken[s_gaddr[i]] = 1'b1;
            end
            if (s_lv[i] && s_cwe[i]) begin
                if (!c_taken[s_caddr[i]]) begin
                    e.cen[i]   = 1'b1;
                    e.caddr[i] = s_caddr[i];
                    e.cdata[i] = s_cdata[i];
                end
                c_taken[s_caddr[i]] = 1'b1;
            end
            if (s_lv[i] && s_hwe[i] && !e.hen) begin
                e.hen   = 1'b1;
                e.hdata = s_hi[i];
            end
            if (s_lv[i] && s_lwe[i] && !e.len) begin
                e.len   = 1'b1;
                e.ldata = s_lo[i];
            end
        end
        return e;
    endfunction

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            model_cnt = '0;
        end else begin
            chk("retire_cnt", 64'(retire_cnt), 64'(model_cnt));
            if (pc_wb != '0 && !wb_hold) begin
                chk("commit_expected", 64'(exp_q.size() > 0), 64'd1);
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    chk("lane_valid", 64'(wb_lane_valid), 64'(mon_e.lv));
                    chk("w_en", 64'(w_en), 64'(mon_e.gen));
                    chk("cp0_w_en", 64'(cp0_w_en), 64'(mon_e.cen));
                    chk("hilo_en", 64'({w_en_hi, w_en_lo}), 64'({mon_e.hen, mon_e.len}));
                    chk("pc_wb", 64'(pc_wb), 64'(mon_e.pc));
                    for (int i = 0; i < L; i++) begin
                        if (mon_e.gen[i]) begin
                            chk($sformatf("w_addr%0d", i), 64'(w_addr[i]), 64'(mon_e.gaddr[i]));
                            chk($sformatf("w_data%0d", i), 64'(w_data[i]), 64'(mon_e.gdata[i]));
                        end
                        if (mon_e.cen[i]) begin
                            chk($sformatf("cp0_addr%0d", i), 64'(cp0_w_addr[i]), 64'(mon_e.caddr[i]));
                            chk($sformatf("cp0_data%0d", i), 64'(cp0_w_data[i]), 64'(mon_e.cdata[i]));
                        end
                    end
                    if (mon_e.hen) chk("data_hi", 64'(data_hi), 64'(mon_e.hdata));
                    if (mon_e.len) chk("data_lo", 64'(data_lo), 64'(mon_e.ldata));
                    model_cnt = model_cnt + CW'($countones(mon_e.lv));
                end
            end else begin
                chk("idle_enables", 64'({wb_lane_valid, w_en, cp0_w_en, w_en_hi, w_en_lo}), 64'd0);
            end
            if (flush) begin
                exp_q.delete();
            end else if (in_valid && in_ready) begin
                exp_q.push_back(model());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic clear_lanes();
        s_lv = '0; s_gwe = '0; s_hwe = '0; s_lwe = '0; s_cwe = '0;
        s_gaddr = '0; s_caddr = '0; s_gdata = '0; s_hi = '0; s_lo = '0; s_cdata = '0;
        pc_base = pc_base + 32'h10;
        for (int i = 0; i < L; i++) s_pc[i] = pc_base + 32'(4 * i);
    endtask

    task automatic set_gpr(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        s_lv[i] = 1'b1; s_gwe[i] = 1'b1; s_gaddr[i] = a; s_gdata[i] = d;
    endtask

    task automatic set_cp0(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        s_lv[i] = 1'b1; s_cwe[i] = 1'b1; s_caddr[i] = a; s_cdata[i] = d;
    endtask

    task automatic rand_bundle();
        clear_lanes();
        for (int i = 0; i < L; i++) begin
            s_lv[i]    = 1'($urandom_range(0, 1));
            s_gwe[i]   = 1'($urandom_range(0, 1));
            s_gaddr[i] = AW'($urandom_range(0, 3));
            s_gdata[i] = $urandom;
            s_hwe[i]   = 1'($urandom_range(0, 1));
            s_lwe[i]   = 1'($urandom_range(0, 1));
            s_hi[i]    = $urandom;
            s_lo[i]    = $urandom;
            s_cwe[i]   = 1'($urandom_range(0, 1));
            s_caddr[i] = AW'($urandom_range(0, 3));
            s_cdata[i] = $urandom;
        end
    endtask

    // Offer the current stimulus until it is accepted (bounded).
    task automatic send();
        int   budget = 200;
        logic acc    = 1'b0;
        in_valid = 1'b1;
        while (!acc && budget > 0) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            budget--;
        end
        in_valid = 1'b0;
        chk("send_accepted", 64'(acc), 64'd1);
    endtask

    task automatic wait_drain();
        int budget = 200;
        while (exp_q.size() != 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        chk("drain", 64'(exp_q.size()), 64'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; wb_hold = 1'b0;
        clear_lanes();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_w_en", 64'(w_en), 64'd0);
        chk("rst_pc_wb", 64'(pc_wb), 64'd0);
        chk("rst_cnt", 64'(retire_cnt), 64'd0);
        @(posedge clk); #1;

        // Single bundle, then a bundle with no lanes present.
        clear_lanes(); set_gpr(0, 5'd3, 32'hDEADBEEF); send();
        wait_drain();
        chk("t1_cnt", 64'(retire_cnt), 64'd1);
        clear_lanes(); send();
        wait_drain();
        chk("t1_empty_cnt", 64'(retire_cnt), 64'd1);

        // Collisions: same GPR, GPR 0, same CP0.
        clear_lanes(); set_gpr(0, 5'd8, 32'h11); set_gpr(1, 5'd8, 32'h22); send();
        clear_lanes(); set_gpr(0, 5'd0, 32'h33); set_gpr(1, 5'd5, 32'h44); send();
        clear_lanes(); set_cp0(0, 5'd12, 32'h55); set_cp0(1, 5'd12, 32'h66); send();
        wait_drain();
        chk("t2_cnt", 64'(retire_cnt), 64'd7);

        // Backpressure: hold for three cycles while streaming.
        wb_hold = 1'b1;
        fork
            begin
                for (int k = 0; k < 4; k++) begin
                    rand_bundle();
                    send();
                end
            end
            begin
                repeat (3) @(posedge clk);
                @(negedge clk);
                chk("t3_full_ready", 64'(in_ready), 64'd0);
                chk("t3_buffered", 64'(exp_q.size()), 64'd2);
                @(posedge clk);
                #1 wb_hold = 1'b0;
            end
        join
        wait_drain();

        // Flush with both entries full and a new bundle offered.
        cnt_snap = model_cnt;
        wb_hold = 1'b1;
        clear_lanes(); set_gpr(0, 5'd1, 32'h100); send();
        clear_lanes(); set_gpr(1, 5'd2, 32'h200); send();
        clear_lanes(); set_gpr(0, 5'd4, 32'h400);
        in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("t4_ready", 64'(in_ready), 64'd1);
        chk("t4_empty_pc", 64'(pc_wb), 64'd0);
        // Flush against a ready buffer: the offered bundle must not be taken.
        clear_lanes(); set_gpr(0, 5'd6, 32'h600); send();
        clear_lanes(); set_gpr(1, 5'd7, 32'h700);
        @(posedge clk); #1;
        in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0; wb_hold = 1'b0;
        repeat (4) @(posedge clk); #1;
        chk("t4_cnt", 64'(retire_cnt), 64'(cnt_snap));

        // HI/LO merge.
        clear_lanes();
        s_lv = 2'b11;
        s_hwe[0] = 1'b1; s_hi[0] = 32'hA;
        s_hwe[1] = 1'b1; s_hi[1] = 32'hB;
        s_lwe[1] = 1'b1; s_lo[1] = 32'hC;
        send();
        wait_drain();

        // Reset with a bundle held in the buffer: it is dropped, not counted.
        wb_hold = 1'b1;
        clear_lanes(); set_gpr(0, 5'd9, 32'h1); send();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; wb_hold = 1'b0;
        repeat (3) @(posedge clk); #1;
        chk("t6_rst_cnt", 64'(retire_cnt), 64'd0);

        // Counter wrap at CNT_W=4: 15 retires, then a two-lane commit.
        for (int k = 0; k < 15; k++) begin
            clear_lanes(); set_gpr(0, AW'(k + 1), 32'(k)); send();
        end
        wait_drain();
        chk("t6_cnt15", 64'(retire_cnt), 64'd15);
        clear_lanes(); set_gpr(0, 5'd1, 32'h77); set_gpr(1, 5'd2, 32'h88); send();
        wait_drain();
        chk("t6_wrap", 64'(retire_cnt), 64'd1);

        // Random stream with random hold.
        fork
            begin
                for (int k = 0; k < 30; k++) begin
                    rand_bundle();
                    send();
                end
            end
            begin
                repeat (60) begin
                    @(posedge clk);
                    #1 wb_hold = ($urandom_range(0, 3) == 0);
                end
                wb_hold = 1'b0;
            end
        join
        wb_hold = 1'b0;
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
